// File: rtl/centroid_detect.sv
// Per-frame foreground centroid: accumulates count and coordinate sums, then divides
// both sums by the count with two bit-serial restoring dividers and hands off (z_x, z_y).
module centroid_detect #(
  parameter int DISP_WIDTH = 11,
  parameter int CNT_W      = 20,
  parameter int SUM_W      = 31,
  parameter int MIN_PIXELS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic                  pix_mask,
  input  logic [DISP_WIDTH-1:0] pix_x,
  input  logic [DISP_WIDTH-1:0] pix_y,
  input  logic                  frame_end,
  output logic [DISP_WIDTH-1:0] z_x,
  output logic [DISP_WIDTH-1:0] z_y,
  output logic                  valid,
  input  logic                  ready,
  output logic                  no_object,
  output logic                  frame_drop
);

  localparam int IT_W = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [IT_W-1:0]  LAST_IT  = IT_W'(SUM_W);

  typedef enum logic [1:0] {IDLE, DIVIDE, PRESENT} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_inc, cnt_d, divisor_q;
  logic [SUM_W-1:0]      sumx_q, sumx_inc, sumx_d;
  logic [SUM_W-1:0]      sumy_q, sumy_inc, sumy_d;
  logic [CNT_W-1:0]      remx_q, remy_q;
  logic [SUM_W-1:0]      quox_q, quoy_q;
  logic [CNT_W+SUM_W-1:0] stepx, stepy;
  logic [IT_W-1:0]       iter_q;
  logic [DISP_WIDTH-1:0] zx_q, zy_q;
  logic                  no_object_q, frame_drop_q;
  logic                  pix_fg, fe, enough, start;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [DISP_WIDTH-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - DISP_WIDTH){1'b0}}, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [CNT_W+SUM_W-1:0] div_step(input logic [CNT_W-1:0] r,
                                                      input logic [SUM_W-1:0] q,
                                                      input logic [CNT_W-1:0] d);
    logic [CNT_W:0]   r_sh;
    logic [CNT_W-1:0] r_new;
    logic             ge;
    r_sh = {r, q[SUM_W-1]};
    ge   = (r_sh >= {1'b0, d});
    if (ge) r_sh = r_sh - {1'b0, d};
    r_new = r_sh[CNT_W-1:0];
    return {r_new, q[SUM_W-2:0], ge};
  endfunction

  always_comb begin
    pix_fg   = pix_valid & pix_mask;
    fe       = pix_valid & frame_end;
    cnt_inc  = pix_fg ? sat_inc(cnt_q)         : cnt_q;
    sumx_inc = pix_fg ? sat_add(sumx_q, pix_x) : sumx_q;
    sumy_inc = pix_fg ? sat_add(sumy_q, pix_y) : sumy_q;
    cnt_d    = fe ? '0 : cnt_inc;
    sumx_d   = fe ? '0 : sumx_inc;
    sumy_d   = fe ? '0 : sumy_inc;
    enough   = (cnt_inc >= MIN_CNT);
    start    = fe && (state_q == IDLE) && enough;
    stepx    = div_step(remx_q, quox_q, divisor_q);
    stepy    = div_step(remy_q, quoy_q, divisor_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DIVIDE;
      DIVIDE:  if (iter_q == LAST_IT) state_d = PRESENT;
      PRESENT: if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sumx_q       <= '0;
      sumy_q       <= '0;
      iter_q       <= '0;
      zx_q         <= '0;
      zy_q         <= '0;
      no_object_q  <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sumx_q       <= sumx_d;
      sumy_q       <= sumy_d;
      no_object_q  <= fe && (state_q == IDLE) && !enough;
      frame_drop_q <= fe && (state_q != IDLE);
      case (state_q)
        IDLE: if (start) begin
          divisor_q <= cnt_inc;
          remx_q    <= '0;
          remy_q    <= '0;
          quox_q    <= sumx_inc;
          quoy_q    <= sumy_inc;
          iter_q    <= '0;
        end
        // SUM_W shift/subtract steps, then one cycle to register the centroid.
        DIVIDE: if (iter_q != LAST_IT) begin
          {remx_q, quox_q} <= stepx;
          {remy_q, quoy_q} <= stepy;
          iter_q           <= iter_q + 1'b1;
        end else begin
          zx_q <= quox_q[DISP_WIDTH-1:0];
          zy_q <= quoy_q[DISP_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign z_x        = zx_q;
  assign z_y        = zy_q;
  assign valid      = (state_q == PRESENT);
  assign no_object  = no_object_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_centroid_detect.sv
// Randomized bench for centroid_detect; expected centroids come from plain
// integer means over the frame's foreground pixel list.
module tb_centroid_detect;

  localparam int DW  = 11;
  localparam int CW  = 20;
  localparam int SW  = 31;
  localparam int MIN = 16;

  logic          clk = 1'b0;
  logic          reset, pix_valid, pix_mask, frame_end, ready;
  logic [DW-1:0] pix_x, pix_y, z_x, z_y;
  logic          valid, no_object, frame_drop;

  int checks = 0;
  int errors = 0;
  int qx[$], qy[$];
  int last_x = 0, last_y = 0;

  centroid_detect #(.DISP_WIDTH(DW), .CNT_W(CW), .SUM_W(SW), .MIN_PIXELS(MIN)) u_dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_mask(pix_mask),
    .pix_x(pix_x), .pix_y(pix_y), .frame_end(frame_end),
    .z_x(z_x), .z_y(z_y), .valid(valid), .ready(ready),
    .no_object(no_object), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic m, input int x, input int y, input logic fe);
    pix_valid = v;
    pix_mask  = m;
    pix_x     = DW'(x);
    pix_y     = DW'(y);
    frame_end = fe;
    ready     = 1'($urandom);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends qx/qy as one frame with random filler beats; the last foreground pixel carries frame_end.
  task automatic send_frame();
    for (int i = 0; i < qx.size(); i++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        if ($urandom_range(0, 1) == 1)
          beat(1'b1, 1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0);
        else
          beat(1'b0, 1'($urandom), $urandom_range(0, 2047), $urandom_range(0, 2047), 1'($urandom));
      end
      beat(1'b1, 1'b1, qx[i], qy[i], i == qx.size() - 1);
    end
  endtask

  task automatic fill(input int n, input int x, input int y);
    qx.delete(); qy.delete();
    for (int i = 0; i < n; i++) begin qx.push_back(x); qy.push_back(y); end
  endtask

  task automatic fill_random(input int n);
    qx.delete(); qy.delete();
    for (int i = 0; i < n; i++) begin
      qx.push_back($urandom_range(0, 2047));
      qy.push_back($urandom_range(0, 2047));
    end
  endtask

  function automatic int mean(input bit is_y);
    longint s = 0;
    for (int i = 0; i < qx.size(); i++) s += is_y ? qy[i] : qx[i];
    return int'(s / qx.size());
  endfunction

  task automatic deliver(input string tag, input int ex, input int ey, input int exp_lat, input int hold);
    int  cycles = 0;
    bit  stable = 1;
    ready = 1'b0;
    while (valid !== 1'b1 && cycles < 200) begin @(posedge clk); #1; cycles++; end
    check({tag, "_valid"}, valid, 1);
    if (exp_lat >= 0) check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_zx"}, z_x, ex);
    check({tag, "_zy"}, z_y, ey);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (valid !== 1'b1 || z_x !== DW'(ex) || z_y !== DW'(ey)) stable = 0;
    end
    check({tag, "_hold_stable"}, stable, 1);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check({tag, "_valid_after_accept"}, valid, 0);
    check({tag, "_zx_kept"}, z_x, ex);
    last_x = ex;
    last_y = ey;
  endtask

  task automatic expect_no_object(input string tag);
    bit quiet = 1;
    check({tag, "_no_object"}, no_object, 1);
    check({tag, "_drop_quiet"}, frame_drop, 0);
    @(posedge clk); #1;
    check({tag, "_no_object_pulse"}, no_object, 0);
    for (int i = 0; i < SW + 5; i++) begin
      if (valid !== 1'b0) quiet = 0;
      @(posedge clk); #1;
    end
    check({tag, "_valid_low"}, quiet, 1);
    check({tag, "_zx_unchanged"}, z_x, last_x);
    check({tag, "_zy_unchanged"}, z_y, last_y);
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_mask = 1'b0; frame_end = 1'b0;
    pix_x = '0; pix_y = '0; ready = 1'b0;
    idle(3);
    check("rst_zx", z_x, 0);
    check("rst_zy", z_y, 0);
    check("rst_valid", valid, 0);
    check("rst_no_object", no_object, 0);
    check("rst_frame_drop", frame_drop, 0);
    reset = 1'b0;
    idle(2);

    // Single coordinate repeated to the minimum count.
    fill(MIN, 100, 50);
    send_frame();
    check("f1_no_object", no_object, 0);
    deliver("f1", mean(0), mean(1), SW + 1, 0);

    // Four-pixel square: means 10.5 / 20.5 must truncate.
    qx.delete(); qy.delete();
    for (int r = 0; r < 4; r++) begin
      qx.push_back(10); qy.push_back(20);
      qx.push_back(11); qy.push_back(20);
      qx.push_back(10); qy.push_back(21);
      qx.push_back(11); qy.push_back(21);
    end
    send_frame();
    check("sq_expect_x", mean(0), 10);
    deliver("sq", 10, 20, SW + 1, 20);

    fill(5, 300, 400);
    send_frame();
    expect_no_object("small5");
    fill(MIN - 1, 300, 400);
    send_frame();
    expect_no_object("small15");

    // Frame end while dividing is dropped; the in-flight result survives.
    fill(MIN, 500, 600);
    send_frame();
    idle(4);
    beat(1'b1, 1'b1, 1, 2, 1'b0);
    beat(1'b1, 1'b1, 3, 4, 1'b1);
    check("drop_pulse", frame_drop, 1);
    check("drop_no_object", no_object, 0);
    idle(1);
    check("drop_pulse_end", frame_drop, 0);
    deliver("drop_inflight", 500, 600, -1, 3);
    fill(MIN, 200, 300);
    send_frame();
    deliver("after_drop", 200, 300, SW + 1, 1);

    // Reset mid-divide aborts the measurement.
    fill(MIN, 1000, 1500);
    send_frame();
    idle(10);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midrst_zx", z_x, 0);
    check("midrst_zy", z_y, 0);
    begin
      bit quiet = 1;
      for (int i = 0; i < SW + 10; i++) begin
        if (valid !== 1'b0) quiet = 0;
        idle(1);
      end
      check("midrst_valid_low", quiet, 1);
    end
    last_x = 0; last_y = 0;
    fill(MIN, 7, 9);
    send_frame();
    deliver("after_rst", 7, 9, SW + 1, 0);

    for (int f = 0; f < 24; f++) begin
      fill_random($urandom_range(8, 40));
      send_frame();
      if (qx.size() < MIN) expect_no_object($sformatf("rnd%0d", f));
      else deliver($sformatf("rnd%0d", f), mean(0), mean(1), SW + 1, $urandom_range(0, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/centroid_detect.md
Name: centroid_detect

Overview:
- Measurement front-end for the object tracker. Consumes a raster stream of binary foreground-mask pixels with their coordinates and accumulates pixel count, sum of x and sum of y per frame.
- At frame end it divides the sums by the count to form the object centroid. It presents the centroid as one (z_x, z_y) measurement to the downstream Kalman stage over a valid/ready handshake.

Parameters:
DISP_WIDTH, 11, width of pixel coordinates and of output centroid
CNT_W, 20, width of foreground pixel counter (covers 640x480)
SUM_W, 31, width of coordinate sum accumulators (CNT_W + DISP_WIDTH)
MIN_PIXELS, 16, minimum foreground count for a frame to produce a measurement

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
pix_valid  in  1  pixel beat qualifier
pix_mask  in  1  1 = pixel is foreground
pix_x  in  DISP_WIDTH  pixel column
pix_y  in  DISP_WIDTH  pixel row
frame_end  in  1  marks last pixel of frame; meaningful only with pix_valid=1
z_x  out  DISP_WIDTH  centroid x (truncated)
z_y  out  DISP_WIDTH  centroid y (truncated)
valid  out  1  centroid available
ready  in  1  downstream accepts centroid
no_object  out  1  one-cycle pulse: frame ended with count < MIN_PIXELS
frame_drop  out  1  one-cycle pulse: frame ended while block busy, stats discarded

Behaviour:
- Reset:
  - Synchronous, active-high, on the clk edge with reset=1.
  - All outputs go to 0: z_x, z_y, valid, no_object, frame_drop.
  - Accumulators are cleared and the FSM goes to IDLE.
  - Reset wins over all other inputs. Reset mid-divide or mid-present aborts the measurement with no valid.
- Accumulation:
  - Every beat with pix_valid=1 and pix_mask=1 adds 1 to cnt, pix_x to sum_x, pix_y to sum_y.
  - Accumulation runs in every FSM state and is independent of the divider.
  - cnt, sum_x and sum_y each saturate at all-ones and never wrap.
- Frame end (pix_valid=1 and frame_end=1):
  - That beat's pixel is included.
  - The resulting totals are snapshotted and the accumulators are cleared to 0 on the same edge. The next beat starts a new frame.
- FSM states: IDLE, DIVIDE, PRESENT.
  - IDLE, on frame end:
    - If snapshot cnt >= MIN_PIXELS, load the divider and go to DIVIDE.
    - Otherwise stay in IDLE and pulse no_object for 1 cycle.
  - DIVIDE:
    - Two parallel restoring dividers (sum_x/cnt and sum_y/cnt) produce 1 quotient bit per cycle, MSB first, for exactly SUM_W cycles, counted by an iteration counter.
    - Then go to PRESENT.
    - Quotients are truncated and take the low DISP_WIDTH bits; the mean is always below 2^DISP_WIDTH.
  - PRESENT:
    - valid=1; z_x and z_y hold the quotients and stay stable while valid=1.
    - When valid and ready are both 1 on an edge, the transfer completes: valid=0 next cycle and the FSM returns to IDLE.
    - valid never drops without ready.
- Latency: if frame end is sampled at edge T, valid is first high after edge T+SUM_W+1.
- z_x and z_y keep the last delivered centroid after the handshake, until the next PRESENT.
- Frame end while in DIVIDE or PRESENT:
  - The snapshot is discarded, accumulators still clear, and frame_drop pulses for 1 cycle.
  - The in-flight measurement continues unaffected.
- Division by zero cannot occur because MIN_PIXELS >= 1 is required; the parameter must be >= 1.
- ready is ignored outside PRESENT.
- pix_* inputs are ignored when pix_valid=0, including frame_end.

Test Plan:
- MIN_PIXELS=1; single foreground pixel (100,50) with frame_end -> after SUM_W+1 cycles valid=1, z_x=100, z_y=50; ready=1 -> valid=0 next cycle.
- Four pixels (10,20),(11,20),(10,21),(11,21), last with frame_end -> sums 42/82, count 4 -> z_x=10, z_y=20 (truncation).
- Frame of 5 foreground pixels with MIN_PIXELS=16 -> no_object pulses 1 cycle, valid stays 0, prior z_x/z_y unchanged.
- Hold ready=0 for 20 cycles after valid rises -> valid, z_x, z_y stable; ready=1 -> accepted once, valid low next cycle.
- Second frame_end arrives 5 cycles into DIVIDE -> frame_drop pulses; first centroid still delivered correctly. A third frame of 16 pixels at (200,300) then yields z=(200,300).
- Assert reset mid-DIVIDE -> valid never rises, outputs 0. Next qualifying frame of 16 pixels at (7,9) yields z=(7,9).
